// File: rtl/missile_ctrl.sv
// Player missile: launch on fire, climb once per frame, detect enemy overlap during the scan
// and emit a one-cycle hit pulse for the enemy formation's kill counter.
module missile_ctrl #(
    parameter int unsigned MISSILE_W       = 2,
    parameter int unsigned MISSILE_H       = 8,
    parameter int unsigned SPEED           = 4,
    parameter logic [9:0]  LAUNCH_Y        = 10'd440,
    parameter logic [9:0]  X_OFFSET        = 10'd15,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic       is_playing,
    input  logic [9:0] ship_x,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       enemy_on,
    output logic       hit,
    output logic       missile_on,
    output logic [7:0] missile_R,
    output logic [7:0] missile_G,
    output logic [7:0] missile_B,
    output logic [9:0] missile_x,
    output logic [9:0] missile_y,
    output logic       active,
    output logic [7:0] shots_fired
);

    localparam int unsigned CntW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

    typedef enum logic [1:0] {StIdle, StFlying, StCooldown} state_e;

    state_e          state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [7:0]      shots_q, shots_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            collide_q, collide_d;
    logic            hit_q, hit_d;
    logic            frame_clk_q, fire_q;
    logic            frame_tick, fire_req;

    logic [10:0] draw_x_w, draw_y_w, x_w, y_w;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= StIdle;
            x_q         <= 10'd0;
            y_q         <= LAUNCH_Y;
            shots_q     <= 8'd0;
            cnt_q       <= '0;
            collide_q   <= 1'b0;
            hit_q       <= 1'b0;
            frame_clk_q <= 1'b0;
            fire_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            shots_q     <= shots_d;
            cnt_q       <= cnt_d;
            collide_q   <= collide_d;
            hit_q       <= hit_d;
            frame_clk_q <= frame_clk;
            fire_q      <= fire;
        end
    end

    assign frame_tick = frame_clk & ~frame_clk_q;
    assign fire_req   = fire & ~fire_q;

    // 11-bit bounds so a missile near the right/bottom edge never wraps its extent.
    assign draw_x_w = {1'b0, DrawX};
    assign draw_y_w = {1'b0, DrawY};
    assign x_w      = {1'b0, x_q};
    assign y_w      = {1'b0, y_q};

    assign missile_on = (state_q == StFlying)
                     && (draw_x_w >= x_w) && (draw_x_w < x_w + 11'(MISSILE_W))
                     && (draw_y_w >= y_w) && (draw_y_w < y_w + 11'(MISSILE_H));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        shots_d   = shots_q;
        cnt_d     = cnt_q;
        collide_d = 1'b0;
        hit_d     = 1'b0;

        if (!is_playing) begin
            // Leaving play drops any pending collision without a hit.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fire_req) begin
                        state_d = StFlying;
                        x_d     = ship_x + X_OFFSET;
                        y_d     = LAUNCH_Y;
                        shots_d = (shots_q == 8'hFF) ? shots_q : shots_q + 8'd1;
                    end
                end
                StFlying: begin
                    if (collide_q) begin
                        // A pending hit beats the frame move; position freezes.
                        hit_d   = 1'b1;
                        state_d = StCooldown;
                        cnt_d   = '0;
                    end else if (frame_tick && (y_q < 10'(SPEED))) begin
                        state_d = StCooldown;
                        cnt_d   = '0;
                    end else begin
                        if (frame_tick) begin
                            y_d = y_q - 10'(SPEED);
                        end
                        collide_d = missile_on & enemy_on;
                    end
                end
                StCooldown: begin
                    if (frame_tick) begin
                        if (cnt_q == CntW'(COOLDOWN_FRAMES - 1)) begin
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign hit         = hit_q;
    assign active      = (state_q == StFlying);
    assign missile_x   = x_q;
    assign missile_y   = y_q;
    assign shots_fired = shots_q;
    assign missile_R   = missile_on ? 8'hFF : 8'h00;
    assign missile_G   = missile_on ? 8'hFF : 8'h00;
    assign missile_B   = 8'h00;

endmodule
